// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, access
// size encodings, requester identity and the size-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Encoding 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the fetch unit, the load/store buffer, the 8-bit RAM
// port and mem_ctrl; the controller connects through the slave modport.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_size, ls_unsigned, ls_wdata,
    input  mem_din,
    output if_done, if_data, ls_done, ls_rdata,
    output mem_a, mem_dout, mem_wr
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_size, ls_unsigned, ls_wdata,
    output mem_din,
    input  if_done, if_data, ls_done, ls_rdata,
    input  mem_a, mem_dout, mem_wr
  );

endinterface

// File: rtl/mem_ctrl_rdata_ext.sv
// Combinational load-data extender: sign- or zero-extends byte and half
// results to 32 bits; word results pass through unchanged.
module rdata_ext
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_size)
      SZ_B:    o_ext = {{24{i_raw[7] & ~i_unsigned}}, i_raw[7:0]};
      SZ_H:    o_ext = {{16{i_raw[15] & ~i_unsigned}}, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetch and load/store requests
// onto an 8-bit RAM port. Define MEM_CTRL_SIGN_EXT_EN to extend load data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rdy_in,
  input  logic       flush,
  mem_ctrl_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  owner_t            r_lastOwner;
  owner_t            w_owner;
  logic              w_grant;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_len;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [31:0]       r_ifData;
  logic [31:0]       r_lsRdata;
  logic [31:0]       w_capData;
  logic [31:0]       w_lsData;
  logic [7:0]        w_wrByte;
`ifdef MEM_CTRL_SIGN_EXT_EN
  logic [1:0]        r_size;
  logic              r_uns;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)      r_state <= IDLE;
    else if (rdy_in) r_state <= w_next;
  end

  // Round-robin on conflict: the requester not served last wins.
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_owner      = r_owner;
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    bus.if_done  = 1'b0;
    bus.ls_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          w_grant = 1'b1;
          if (bus.if_req && bus.ls_req)
            w_owner = (r_lastOwner == OWN_IF) ? OWN_LS : OWN_IF;
          else
            w_owner = bus.ls_req ? OWN_LS : OWN_IF;
          w_next = (w_owner == OWN_LS && bus.ls_we) ? WRITE : READ;
        end
      end
      READ: begin
        if (r_cnt != r_len) bus.mem_a = r_base + ADDR_W'(r_cnt);
        if (flush)               w_next = IDLE;
        else if (r_cnt == r_len) w_next = DONE;
      end
      WRITE: begin
        bus.mem_a    = r_base + ADDR_W'(r_cnt);
        bus.mem_dout = w_wrByte;
        bus.mem_wr   = rdy_in;
        if (r_cnt == r_len - 3'd1) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
        if (rdy_in && (r_we || !flush)) begin
          bus.if_done = (r_owner == OWN_IF);
          bus.ls_done = (r_owner == OWN_LS);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_capData = r_data;
    case (r_cnt)
      3'd1:    w_capData[7:0]   = bus.mem_din;
      3'd2:    w_capData[15:8]  = bus.mem_din;
      3'd3:    w_capData[23:16] = bus.mem_din;
      3'd4:    w_capData[31:24] = bus.mem_din;
      default: w_capData = r_data;
    endcase
  end

  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_wrByte = r_wdata[7:0];
      2'd1:    w_wrByte = r_wdata[15:8];
      2'd2:    w_wrByte = r_wdata[23:16];
      default: w_wrByte = r_wdata[31:24];
    endcase
  end

`ifdef MEM_CTRL_SIGN_EXT_EN
  rdata_ext u_ext (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_raw      (w_capData),
    .o_ext      (w_lsData)
  );
`else
  assign w_lsData = w_capData;
`endif

  // Byte i-1 lands one cycle after its address, so reads run one count past N.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_lastOwner <= OWN_IF;
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_data      <= '0;
      r_ifData    <= '0;
      r_lsRdata   <= '0;
`ifdef MEM_CTRL_SIGN_EXT_EN
      r_size      <= SZ_W;
      r_uns       <= 1'b0;
`endif
    end else if (rdy_in) begin
      if (w_grant) begin
        r_owner     <= w_owner;
        r_lastOwner <= w_owner;
        r_base      <= (w_owner == OWN_LS) ? bus.ls_addr : bus.if_addr;
        r_len       <= (w_owner == OWN_LS) ? size_bytes(bus.ls_size) : 3'd4;
        r_we        <= (w_owner == OWN_LS) && bus.ls_we;
        r_wdata     <= bus.ls_wdata;
        r_data      <= '0;
        r_cnt       <= '0;
`ifdef MEM_CTRL_SIGN_EXT_EN
        r_size      <= (w_owner == OWN_LS) ? bus.ls_size : SZ_W;
        r_uns       <= bus.ls_unsigned;
`endif
      end else if (r_state == READ || r_state == WRITE) begin
        r_cnt <= (w_next == r_state) ? r_cnt + 3'd1 : '0;
        if (r_state == READ && r_cnt != 3'd0) r_data <= w_capData;
        if (r_state == READ && w_next == DONE) begin
          if (r_owner == OWN_IF) r_ifData  <= w_capData;
          else                   r_lsRdata <= w_lsData;
        end
      end
    end
  end

  assign bus.if_data  = r_ifData;
  assign bus.ls_rdata = r_lsRdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model;
// expected values are hand-computed from the RAM contents each test loads.
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;

  int checks = 0;
  int errors = 0;
  int wrCount = 0;

  bit [7:0] ram [0:1048575];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: contents preloaded while reset is held, one-cycle read latency.
  always @(posedge clk_in) begin
    if (!rst_n) begin
      ram[20'h00100] <= 8'h13;
      ram[20'h00101] <= 8'h05;
      ram[20'h00102] <= 8'h00;
      ram[20'h00103] <= 8'h00;
      ram[20'h00020] <= 8'h80;
      ram[20'h00030] <= 8'h34;
      ram[20'h00031] <= 8'h92;
      ram[20'h00040] <= 8'h5A;
    end else if (rdy_in && bus.mem_wr) begin
      ram[bus.mem_a[19:0]] <= bus.mem_dout;
      wrCount <= wrCount + 1;
    end
    if (rdy_in) bus.mem_din <= ram[bus.mem_a[19:0]];
  end

  logic [31:0] ldAddr [4] = '{32'h20, 32'h20, 32'h30, 32'h30};
  logic [1:0]  ldSize [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic        ldUns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] ldExt  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234, 32'h00009234};
  logic [31:0] ldRaw  [4] = '{32'h00000080, 32'h00000080, 32'h00009234, 32'h00009234};

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done} !== 43'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus got a=%h d=%h wr=%b ifd=%b lsd=%b expected all 0",
               bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done);
    end
    checks++;
    if ({bus.if_data, bus.ls_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got if=%h ls=%h expected 0", bus.if_data, bus.ls_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({bus.mem_a, bus.mem_wr, bus.if_done, bus.ls_done} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got a=%h wr=%b expected 0", bus.mem_a, bus.mem_wr);
    end
  endtask

  task automatic test_fetch;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (c <= 4) begin
        checks++;
        if (bus.mem_a !== 32'h100 + 32'(c - 1)) begin
          errors++;
          $display("[TB] FAIL fetch_addr c%0d got %h expected %h", c, bus.mem_a, 32'h100 + 32'(c - 1));
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.if_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fetch_early_done got %b expected 0", bus.if_done);
        end
      end
    end
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_data !== 32'h00000513) begin
      errors++;
      $display("[TB] FAIL fetch_done got done=%b data=%h expected 1 00000513", bus.if_done, bus.if_data);
    end
    bus.if_req = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.if_done !== 1'b0 || bus.mem_a !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fetch_idle got done=%b a=%h expected 0 0", bus.if_done, bus.mem_a);
    end
  endtask

  task automatic test_load;
    logic [31:0] exp;
    int n;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_CTRL_SIGN_EXT_EN
      exp = ldExt[k];
`else
      exp = ldRaw[k];
`endif
      n = (ldSize[k] == 2'd1) ? 2 : 1;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = ldAddr[k];
      bus.ls_size = ldSize[k]; bus.ls_unsigned = ldUns[k];
      repeat (n + 1) @(negedge clk_in);
      checks++;
      if (bus.ls_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL load_early_done v%0d got %b expected 0", k, bus.ls_done);
      end
      @(negedge clk_in);
      checks++;
      if (bus.ls_done !== 1'b1 || bus.ls_rdata !== exp) begin
        errors++;
        $display("[TB] FAIL load_data v%0d got done=%b data=%h expected 1 %h", k, bus.ls_done, bus.ls_rdata, exp);
      end
      bus.ls_req = 1'b0;
      @(negedge clk_in);
    end
  endtask

  task automatic test_store_half;
    logic [31:0] base [2] = '{32'h0003FFFF, 32'hFFFFFFFF};
    logic [31:0] wd   [2] = '{32'hDEADBEEF, 32'h00001234};
    logic [31:0] expA;
    logic [7:0]  expD;
    for (int k = 0; k < 2; k++) begin
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = base[k];
      bus.ls_size = 2'd1; bus.ls_wdata = wd[k];
      for (int c = 1; c <= 2; c++) begin
        @(negedge clk_in);
        expA = base[k] + 32'(c - 1);
        expD = wd[k][8*(c-1) +: 8];
        checks++;
        if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, expA, expD}) begin
          errors++;
          $display("[TB] FAIL store_beat v%0d c%0d got wr=%b a=%h d=%h expected 1 %h %h",
                   k, c, bus.mem_wr, bus.mem_a, bus.mem_dout, expA, expD);
        end
      end
      @(negedge clk_in);
      checks++;
      if (bus.ls_done !== 1'b1 || bus.mem_wr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL store_done v%0d got done=%b wr=%b expected 1 0", k, bus.ls_done, bus.mem_wr);
      end
      bus.ls_req = 1'b0;
      @(negedge clk_in);
    end
    checks++;
    if ({ram[20'h40000], ram[20'h3FFFF], ram[20'h00000], ram[20'hFFFFF]} !== 32'hBEEF1234) begin
      errors++;
      $display("[TB] FAIL store_ram got %h %h %h %h expected BE EF 12 34",
               ram[20'h40000], ram[20'h3FFFF], ram[20'h00000], ram[20'hFFFFF]);
    end
  endtask

  task automatic test_conflict;
    bit seen;
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h40;
    bus.ls_size = 2'd0; bus.ls_unsigned = 1'b1;
    @(negedge clk_in);
    checks++;
    if (bus.mem_a !== 32'h40) begin
      errors++;
      $display("[TB] FAIL conflict_first got a=%h expected 00000040", bus.mem_a);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (bus.ls_done !== 1'b1 || bus.if_done !== 1'b0 || bus.ls_rdata !== 32'h5A) begin
      errors++;
      $display("[TB] FAIL conflict_ls_done got lsd=%b ifd=%b data=%h expected 1 0 0000005a",
               bus.ls_done, bus.if_done, bus.ls_rdata);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (bus.mem_a !== 32'h100) begin
      errors++;
      $display("[TB] FAIL conflict_second got a=%h expected 00000100", bus.mem_a);
    end
    repeat (5) @(negedge clk_in);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_data !== 32'h00000513) begin
      errors++;
      $display("[TB] FAIL conflict_if_done got done=%b data=%h expected 1 00000513", bus.if_done, bus.if_data);
    end
    bus.if_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_in);
      seen = bus.ls_done;
    end
    checks++;
    if (seen !== 1'b1 || bus.ls_rdata !== 32'h5A) begin
      errors++;
      $display("[TB] FAIL conflict_ls_again got done=%b data=%h expected 1 0000005a", seen, bus.ls_rdata);
    end
    bus.ls_req = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_flush;
    int doneCnt = 0;
    int wrBefore;
    logic [31:0] word;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    flush = 1'b1; bus.if_req = 1'b0;
    @(negedge clk_in);
    flush = 1'b0;
    checks++;
    if (bus.mem_a !== 32'h0 || bus.if_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle got a=%h done=%b expected 0 0", bus.mem_a, bus.if_done);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (bus.if_done === 1'b1) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin
      errors++;
      $display("[TB] FAIL flush_no_done got %0d pulses expected 0", doneCnt);
    end
    wrBefore = wrCount;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h200;
    bus.ls_size = 2'd2; bus.ls_wdata = 32'h11223344;
    repeat (2) @(negedge clk_in);
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (bus.ls_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_store_done got %b expected 1", bus.ls_done);
    end
    bus.ls_req = 1'b0;
    @(negedge clk_in);
    word = {ram[20'h203], ram[20'h202], ram[20'h201], ram[20'h200]};
    checks++;
    if (wrCount - wrBefore !== 4 || word !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL flush_store_data got writes=%0d word=%h expected 4 11223344", wrCount - wrBefore, word);
    end
  endtask

  task automatic test_rdy_stall;
    int wrBefore = wrCount;
    bit seen = 1'b0;
    logic [31:0] word;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h300;
    bus.ls_size = 2'd2; bus.ls_wdata = 32'hA1B2C3D4;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_wr_now got %b expected 0", bus.mem_wr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      checks++;
      if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h301 || bus.ls_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold c%0d got wr=%b a=%h done=%b expected 0 00000301 0",
                 c, bus.mem_wr, bus.mem_a, bus.ls_done);
      end
    end
    rdy_in = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h301 || bus.mem_dout !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL stall_resume got wr=%b a=%h d=%h expected 1 00000301 c3",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk_in);
      seen = bus.ls_done;
    end
    bus.ls_req = 1'b0;
    @(negedge clk_in);
    word = {ram[20'h303], ram[20'h302], ram[20'h301], ram[20'h300]};
    checks++;
    if (seen !== 1'b1 || wrCount - wrBefore !== 4 || word !== 32'hA1B2C3D4) begin
      errors++;
      $display("[TB] FAIL stall_store got done=%b writes=%0d word=%h expected 1 4 a1b2c3d4",
               seen, wrCount - wrBefore, word);
    end
  endtask

  task automatic test_reset_mid_read;
    int doneCnt = 0;
    bit seen = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b0; bus.if_req = 1'b0;
    #1;
    checks++;
    if ({bus.mem_a, bus.mem_wr, bus.if_done, bus.ls_done, bus.if_data} !== 67'h0) begin
      errors++;
      $display("[TB] FAIL midread_reset got a=%h wr=%b ifd=%b data=%h expected all 0",
               bus.mem_a, bus.mem_wr, bus.if_done, bus.if_data);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (bus.if_done === 1'b1) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin
      errors++;
      $display("[TB] FAIL midread_no_done got %0d pulses expected 0", doneCnt);
    end
    bus.if_req = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk_in);
      seen = bus.if_done;
    end
    checks++;
    if (seen !== 1'b1 || bus.if_data !== 32'h00000513) begin
      errors++;
      $display("[TB] FAIL midread_refetch got done=%b data=%h expected 1 00000513", seen, bus.if_data);
    end
    bus.if_req = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
    bus.ls_size = 2'd0; bus.ls_unsigned = 1'b0; bus.ls_wdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store_half();
    test_conflict();
    test_flush();
    test_rdy_stall();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t before summary", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller sitting between the instruction-fetch unit, the load/store buffer (LSB) and the 8-bit unified RAM port. It arbitrates between the two requesters and sequences 1/2/4-byte reads and writes one byte per cycle. It assembles little-endian read data and, when configured, returns load data already sign/zero-extended to 32 bits.

## Interface
Parameters:
- ADDR_W, 32, address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low freezes the block.
- flush  in  1  pipeline flush (mispredict); aborts reads.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  ADDR_W  fetch address (always 4-byte read).
- if_done  out  1  one-cycle pulse, if_data valid.
- if_data  out  32  fetched word.
- ls_req  in  1  load/store request, level, held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  byte address, unaligned allowed.
- ls_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- ls_unsigned  in  1  zero-extend load (LBU/LHU).
- ls_wdata  in  32  store data, low bytes used.
- ls_done  out  1  one-cycle pulse; ls_rdata valid for loads.
- ls_rdata  out  32  load result.
- mem_a  out  ADDR_W  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  RAM write enable.
- mem_din  in  8  RAM read byte, valid one cycle after its address.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: samples if_req/ls_req. Single requester is granted. If both are pending, grant the one not granted last (last_owner register, reset = IF, so LS wins the first conflict). Latch owner, base address, byte count N (1/2/4), ls_we, ls_unsigned, ls_wdata.
- READ: counter i = 0..N-1 drives mem_a = base+i. Byte i is captured from mem_din one cycle later into data[8i+7:8i]. After the last capture -> DONE.
- WRITE: drives mem_a = base+i, mem_dout = wdata[8i+7:8i], mem_wr = 1 for i = 0..N-1, then -> DONE.
- DONE: pulses owner's done for one cycle with registered data, then -> IDLE. Requester drops req on the edge ending the done cycle. IDLE does not sample during DONE.
- Unused upper bytes of a read are 0 before extension.
- flush in READ or DONE-of-a-read: -> IDLE next edge with no done pulse. flush during WRITE is ignored; the store completes and pulses ls_done.
- rdy_in low: all registers hold, mem_wr forced 0, done outputs forced 0. mem_din is held by the environment.
- Reset at any point: immediately IDLE, counters 0, last_owner = IF.

## Timing
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_done = 0, ls_done = 0, if_data = 0, ls_rdata = 0.
- Request sampled at edge E0. Read of N bytes: addresses in cycles 1..N, captures at ends of cycles 2..N+1, done in cycle N+2. Word fetch: done 6 cycles after the sampling edge.
- Write of N bytes: mem_wr in cycles 1..N, ls_done in cycle N+1.
- Back-to-back: next grant sampled earliest in cycle after DONE.
- In IDLE/DONE: mem_wr = 0, mem_a = 0.

## Configuration
- MEM_CTRL_SIGN_EXT_EN defined: ls_rdata is extended per ls_size/ls_unsigned. Byte and half reads are sign-extended from bit 7/15 unless unsigned, otherwise zero-extended. Words are passed unchanged.
- Undefined: ls_rdata returns the raw zero-padded bytes; extension is done downstream. if_data is unaffected either way.

## Structure
- Package mem_ctrl_pkg: state enum (IDLE/READ/WRITE/DONE), size encodings (SZ_B/SZ_H/SZ_W), owner encoding (OWN_IF/OWN_LS), byte-count function size->N.
- One sub-module, rdata_ext: combinational extender (size, unsigned, raw32 -> ext32). Instantiated only under MEM_CTRL_SIGN_EXT_EN.

## Test plan
- Fetch: RAM[0x100..0x103] = 13,05,00,00; if_req with addr 0x100 -> mem_a 0x100..0x103, if_done in cycle 6, if_data = 0x00000513.
- Signed byte load: RAM[0x20] = 0x80, ls_size 0, unsigned 0 -> ls_rdata = 0xFFFFFF80 (0x00000080 with macro off). Same with unsigned 1 -> 0x00000080.
- Store half: ls_wdata 0xDEADBEEF to 0x3FFFF -> mem_wr cycles 1-2, writes EF at 0x3FFFF and BE at 0x40000, ls_done cycle 3. Address 0xFFFFFFFF wraps to 0x0.
- Conflict: if_req and ls_req together from reset -> LS served first, then IF. Both held again -> IF first.
- flush in cycle 3 of a fetch -> no if_done, IDLE next cycle. flush during a word store -> four writes and ls_done still occur.
- rst_n low mid-read, and rdy_in low for 3 cycles mid-store -> outputs reset / mem_wr 0 while low, store resumes at same byte with correct final data.
